seg_display_scanner: RTL and testbench
======================================

// Module: seg_display_scanner
// PURPOSE
//  Time-multiplexed driver for the 6-digit common-anode 7-segment display.
//  Sits directly downstream of the seven-segment encoder and consumes its
//  42-bit time_segments word (HH:MM:SS, 7 active-high segments per digit).
//  Drives one digit at a time with active-low anode and segment lines.
//  Frame-synchronous shadow capture prevents tearing; per-slot blanking
//  prevents ghosting.
// PARAMETERS
//  REFRESH_DIV   50000       clk cycles per digit slot (1 kHz/digit, ~167 Hz frame)
//  BLANK_CYCLES  500         cycles at start of each slot with all anodes off; must be < REFRESH_DIV
//  BLINK_DIV     12500000    cycles per blink half-period (DISP_ALARM_BLINK_EN only)
// PORTS
//  clk_50Mhz      in   1   system clock, 50 MHz
//  reset          in   1   asynchronous, active-high
//  time_segments  in   42  digit k = bits[7k+6:7k]; k=0 seconds units ... k=5 hours tens; 1 = lit
//  alarm_trigger  in   1   alarm active; used only with DISP_ALARM_BLINK_EN
//  an_n           out  6   digit anodes, active-low, bit k = digit k
//  seg_n          out  7   segments a..g, active-low (seg_n = ~shadow digit)
//  dp_n           out  1   decimal point, active-low
// BEHAVIOUR
//  Reset (async, applies in the same cycle): an_n=6'h3F, seg_n=7'h7F, dp_n=1,
//   slot counter=0, digit_idx=0, shadow=0, blink counter=0, blink_phase=0.
//  Slot counter r counts 0..REFRESH_DIV-1 and wraps; on the wrap, digit_idx
//   advances 0->1->...->5->0.
//  frame_start: first cycle after reset release, and every cycle in which
//   digit_idx wraps 5->0. shadow <= time_segments on frame_start only.
//   Input changes mid-frame are not shown until the next digit 0.
//  Outputs are registered with 1-cycle latency from (r, digit_idx, shadow):
//   r < BLANK_CYCLES  -> an_n=6'h3F, seg_n=7'h7F, dp_n=1.
//   otherwise         -> an_n = ~(1<<digit_idx), seg_n = ~shadow[digit_idx],
//                        dp_n = 0 for digit_idx in {2,4} (HH.MM.SS separators), else 1.
//  At most one an_n bit is low in any cycle. Each slot has exactly
//   BLANK_CYCLES all-off cycles.
//  Reset mid-slot: outputs blank immediately. After release, the scan
//   restarts at digit 0 with a fresh shadow capture.
// CONFIGURATION
//  DISP_ALARM_BLINK_EN defined: while alarm_trigger=1, the blink counter
//   counts 0..BLINK_DIV-1 and toggles blink_phase on each wrap. When
//   blink_phase=1, an_n=6'h3F, seg_n=7'h7F, dp_n=1 regardless of the scan.
//   While alarm_trigger=0, the counter and phase are held at 0; normal
//   display resumes on the next registered output. The scan and shadow
//   keep running during blink.
//  Not defined: no blink logic; alarm_trigger is unconnected internally.
// STRUCTURE
//  disp_pkg: NUM_DIGITS=6, SEG_W=7, localparam digit index width (3),
//   ALL_OFF_AN=6'h3F, ALL_OFF_SEG=7'h7F, DP_DIGIT_MASK=6'b010100.
//  Sub-module refresh_timer: slot counter, slot_tick (wrap pulse) and
//   blank flag (r < BLANK_CYCLES).
//  The top level holds digit_idx, shadow, output registers and blink logic.
// TESTING  (bench params REFRESH_DIV=10, BLANK_CYCLES=2, BLINK_DIV=40)
//  1 Assert reset mid-slot at digit 3 -> same cycle an_n=3F, seg_n=7F,
//    dp_n=1; release -> digit 0 is the first digit lit.
//  2 time_segments digit k = 7'h01<<k -> an_n sequence 3E,3D,3B,37,2F,1F
//    and wrap to 3E; seg_n = ~(7'h01<<k) during each lit window of 8 cycles.
//  3 Change time_segments to 42'h0 while digit 2 is lit -> digits 3..5 still
//    show the old pattern; from next digit 0, seg_n=7F in all lit windows.
//  4 Run 3 frames -> exactly 2 all-off cycles per slot; never more than one
//    an_n bit low; dp_n=0 only in the digit 2 and digit 4 lit windows.
//  5 (macro on) alarm_trigger=1 -> 40 cycles normal, 40 cycles blank,
//    repeating; drop alarm_trigger during blank -> normal output the cycle
//    after the next register update.
//  6 (macro off) alarm_trigger toggling -> outputs identical to test 2.

Source files
------------

// File: rtl/disp_pkg.sv
// rtl/disp_pkg.sv - shared constants and helpers for the 7-segment display scanner
// Shared by seg_display_scanner and refresh_timer.
package disp_pkg;

   localparam int NUM_DIGITS = 6;
   localparam int SEG_W      = 7;
   localparam int IDX_W      = 3;
   localparam int TIME_W     = NUM_DIGITS * SEG_W;

   localparam logic [NUM_DIGITS-1:0] ALL_OFF_AN    = 6'h3F;
   localparam logic [SEG_W-1:0]      ALL_OFF_SEG   = 7'h7F;
   localparam logic [NUM_DIGITS-1:0] DP_DIGIT_MASK = 6'b010100;

   typedef logic [IDX_W-1:0] digit_idx_t;

   typedef struct packed {
      logic [NUM_DIGITS-1:0] an_n;
      logic [SEG_W-1:0]      seg_n;
      logic                  dp_n;
   } disp_drive_t;

   localparam disp_drive_t DRIVE_OFF = '{an_n: ALL_OFF_AN, seg_n: ALL_OFF_SEG, dp_n: 1'b1};

   function automatic digit_idx_t next_digit(input digit_idx_t idx);
      return (idx == digit_idx_t'(NUM_DIGITS - 1)) ? '0 : idx + digit_idx_t'(1);
   endfunction

   // Active-low anode pattern selecting exactly one digit.
   function automatic logic [NUM_DIGITS-1:0] anode_for(input digit_idx_t idx);
      logic [NUM_DIGITS-1:0] one_hot;
      one_hot = '0;
      for (int k = 0; k < NUM_DIGITS; k++) begin
         if (idx == digit_idx_t'(k)) one_hot[k] = 1'b1;
      end
      return ~one_hot;
   endfunction

endpackage

// File: rtl/seg_display_scanner_refresh_timer.sv
// rtl/seg_display_scanner_refresh_timer.sv - digit slot counter with wrap tick and blanking flag
// slot_tick marks the last cycle of each slot; blank covers the first BLANK_CYCLES cycles.
module refresh_timer
   import disp_pkg::*;
#(
   parameter int REFRESH_DIV  = 50000,
   parameter int BLANK_CYCLES = 500
) (
   input  logic clk,
   input  logic rst,
   output logic slot_tick,
   output logic blank
);

   localparam int CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
   localparam logic [CNT_W-1:0] LAST  = CNT_W'(REFRESH_DIV - 1);
   localparam logic [CNT_W-1:0] BLANK = CNT_W'(BLANK_CYCLES);

   logic [CNT_W-1:0] r;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r <= '0;
      end else if (r == LAST) begin
         r <= '0;
      end else begin
         r <= r + CNT_W'(1);
      end
   end

   assign slot_tick = (r == LAST);
   assign blank     = (r < BLANK);

endmodule

// File: rtl/seg_display_scanner.sv
// rtl/seg_display_scanner.sv - time-multiplexed 6-digit common-anode 7-segment driver
// Optional alarm blinking is built when DISP_ALARM_BLINK_EN is defined.
module seg_display_scanner
   import disp_pkg::*;
#(
   parameter int REFRESH_DIV  = 50000,
   parameter int BLANK_CYCLES = 500,
   parameter int BLINK_DIV    = 12500000
) (
   input  logic                  clk_50Mhz,
   input  logic                  reset,
   input  logic [TIME_W-1:0]     time_segments,
   input  logic                  alarm_trigger,
   output logic [NUM_DIGITS-1:0] an_n,
   output logic [SEG_W-1:0]      seg_n,
   output logic                  dp_n
);

   logic              slot_tick;
   logic              slot_blank;
   logic              first_cycle;
   logic              frame_start;
   logic              blink_off;
   digit_idx_t        digit_idx;
   logic [TIME_W-1:0] shadow;
   logic [SEG_W-1:0]  cur_digit;
   logic              cur_dp;
   disp_drive_t       drive_next;

   refresh_timer #(
      .REFRESH_DIV (REFRESH_DIV),
      .BLANK_CYCLES(BLANK_CYCLES)
   ) u_refresh_timer (
      .clk      (clk_50Mhz),
      .rst      (reset),
      .slot_tick(slot_tick),
      .blank    (slot_blank)
   );

   // A fresh frame begins right after reset and whenever the scan leaves the last digit.
   assign frame_start = first_cycle |
                        (slot_tick & (digit_idx == digit_idx_t'(NUM_DIGITS - 1)));

   always_comb begin
      cur_digit = '0;
      cur_dp    = 1'b0;
      for (int k = 0; k < NUM_DIGITS; k++) begin
         if (digit_idx == digit_idx_t'(k)) begin
            cur_digit = shadow[k*SEG_W +: SEG_W];
            cur_dp    = DP_DIGIT_MASK[k];
         end
      end
   end

   always_comb begin
      drive_next = DRIVE_OFF;
      if (!slot_blank && !blink_off) begin
         drive_next.an_n  = anode_for(digit_idx);
         drive_next.seg_n = ~cur_digit;
         drive_next.dp_n  = ~cur_dp;
      end
   end

   always_ff @(posedge clk_50Mhz or posedge reset) begin
      if (reset) begin
         first_cycle <= 1'b1;
         digit_idx   <= '0;
         shadow      <= '0;
         an_n        <= ALL_OFF_AN;
         seg_n       <= ALL_OFF_SEG;
         dp_n        <= 1'b1;
      end else begin
         first_cycle <= 1'b0;
         if (frame_start) shadow <= time_segments;
         if (slot_tick) digit_idx <= next_digit(digit_idx);
         an_n  <= drive_next.an_n;
         seg_n <= drive_next.seg_n;
         dp_n  <= drive_next.dp_n;
      end
   end

`ifdef DISP_ALARM_BLINK_EN
   localparam int BL_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
   localparam logic [BL_W-1:0] BLINK_LAST = BL_W'(BLINK_DIV - 1);

   logic [BL_W-1:0] blink_cnt;
   logic            blink_phase;

   // The scan keeps running underneath; blinking only gates the registered drive.
   always_ff @(posedge clk_50Mhz or posedge reset) begin
      if (reset) begin
         blink_cnt   <= '0;
         blink_phase <= 1'b0;
      end else if (!alarm_trigger) begin
         blink_cnt   <= '0;
         blink_phase <= 1'b0;
      end else if (blink_cnt == BLINK_LAST) begin
         blink_cnt   <= '0;
         blink_phase <= ~blink_phase;
      end else begin
         blink_cnt <= blink_cnt + BL_W'(1);
      end
   end

   assign blink_off = blink_phase;
`else
   logic unused_blink;

   assign unused_blink = alarm_trigger | (BLINK_DIV < 1);
   assign blink_off    = 1'b0;
`endif

endmodule

// File: tb/tb_seg_display_scanner.sv
// tb/tb_seg_display_scanner.sv - scoreboard bench for seg_display_scanner
// Reference model derives every expected drive from the cycle count since reset release.
module tb_seg_display_scanner;

   localparam int RD   = 10;
   localparam int BC   = 2;
   localparam int BD   = 40;
   localparam int ND   = 6;
   localparam int FRM  = RD * ND;

   typedef struct {
      logic [5:0] an;
      logic [6:0] seg;
      logic       dp;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [41:0] ts = '0;
   logic        alarm = 1'b0;
   logic [5:0]  an_n;
   logic [6:0]  seg_n;
   logic        dp_n;

   int   n_checks = 0;
   int   n_pass   = 0;
   int   t        = 0;
   int   n_alarm  = 0;
   logic [41:0] m_shadow = '0;
   exp_t exp_q[$];

   seg_display_scanner #(
      .REFRESH_DIV (RD),
      .BLANK_CYCLES(BC),
      .BLINK_DIV   (BD)
   ) dut (
      .clk_50Mhz    (clk),
      .reset        (rst),
      .time_segments(ts),
      .alarm_trigger(alarm),
      .an_n         (an_n),
      .seg_n        (seg_n),
      .dp_n         (dp_n)
   );

   always #5 clk = ~clk;

   task automatic chk(input bit ok, input string name, input logic [63:0] act, input logic [63:0] req);
      n_checks++;
      if (ok) n_pass++;
      else $display("FAIL %s: got %h, expected %h (t=%0d)", name, act, req, t);
   endtask

   // Reference model: slot, digit and frame follow from t; shadow is what time_segments held
   // at the frame boundary; blinking follows from the length of the current alarm run.
   always @(posedge clk or posedge rst) begin
      exp_t e;
      int   pos, dig;
      bit   off;
      if (rst) begin
         t        = 0;
         n_alarm  = 0;
         m_shadow = '0;
         exp_q.delete();
      end else begin
         pos = t % RD;
         dig = (t / RD) % ND;
         off = (pos < BC);
`ifdef DISP_ALARM_BLINK_EN
         if (((n_alarm / BD) % 2) == 1) off = 1'b1;
         n_alarm = alarm ? n_alarm + 1 : 0;
`endif
         if (off) begin
            e.an = 6'h3F; e.seg = 7'h7F; e.dp = 1'b1;
         end else begin
            e.an  = ~(6'd1 << dig);
            e.seg = ~m_shadow[dig*7 +: 7];
            e.dp  = !(dig == 2 || dig == 4);
         end
         exp_q.push_back(e);
         if (t == 0 || (t % FRM) == FRM - 1) m_shadow = ts;
         t++;
      end
   end

   // Monitor: compares the registered drive half a cycle after each update.
   always @(negedge clk) begin
      exp_t e;
      if (rst) begin
         chk({an_n, seg_n, dp_n} == {6'h3F, 7'h7F, 1'b1}, "reset_off",
             64'({an_n, seg_n, dp_n}), 64'({6'h3F, 7'h7F, 1'b1}));
      end else if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         chk({an_n, seg_n, dp_n} == {e.an, e.seg, e.dp}, "drive",
             64'({an_n, seg_n, dp_n}), 64'({e.an, e.seg, e.dp}));
         chk($countones(~an_n) <= 1, "one_anode", 64'(an_n), 64'(e.an));
      end
   end

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #2;
   endtask

   task automatic wait_phase(input int ph);
      int guard = 0;
      while ((t % FRM) != ph && guard < 2 * FRM) begin
         step(1);
         guard++;
      end
      chk((t % FRM) == ph, "wait_phase", 64'(t % FRM), 64'(ph));
   endtask

   task automatic set_walking();
      for (int k = 0; k < ND; k++) ts[k*7 +: 7] = 7'h01 << k;
   endtask

   initial begin
      int guard;
      set_walking();
      step(3);
      rst = 1'b0;
      step(2 * FRM + 5);

      // blank the input while digit 2 is lit; the rest of the frame keeps the old pattern
      wait_phase(25);
      ts = '0;
      step(2 * FRM);

      for (int i = 0; i < 8; i++) begin
         ts = {10'($urandom), 32'($urandom)};
         step($urandom_range(5, 90));
      end

      // reset in the middle of digit 3
      set_walking();
      wait_phase(35);
      rst = 1'b1;
      #1;
      chk({an_n, seg_n, dp_n} == {6'h3F, 7'h7F, 1'b1}, "async_reset",
          64'({an_n, seg_n, dp_n}), 64'({6'h3F, 7'h7F, 1'b1}));
      step(3);
      rst = 1'b0;
      guard = 0;
      @(negedge clk);
      while (an_n == 6'h3F && guard < 3 * RD) begin
         @(negedge clk);
         guard++;
      end
      chk(an_n == 6'h3E, "first_digit_after_reset", 64'(an_n), 64'(6'h3E));
      #2;
      step(FRM);

`ifdef DISP_ALARM_BLINK_EN
      alarm = 1'b1;
      step(2 * BD + BD / 2);
      alarm = 1'b0;
      step(BD / 2);
      for (int i = 0; i < 6; i++) begin
         alarm = ~alarm;
         ts    = {10'($urandom), 32'($urandom)};
         step($urandom_range(10, 120));
      end
      alarm = 1'b0;
`else
      for (int i = 0; i < 20; i++) begin
         alarm = 1'($urandom);
         step($urandom_range(1, 15));
      end
      alarm = 1'b0;
`endif
      step(FRM);
      @(negedge clk);
      #1;
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
